// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the two-requester memory arbiter
package mem_arb_pkg;

    localparam int NUM_RQ = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RDRET = 2'd3
    } state_t;

    typedef enum logic {
        CMD_WR = 1'b0,
        CMD_RD = 1'b1
    } cmd_t;

endpackage

// File: rtl/mem_arb_if.sv
// rtl/mem_arb_if.sv - requester-side and memory-side bus bundle of the memory arbiter
interface mem_arb_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    import mem_arb_pkg::*;

    localparam int BE_W = DATA_W / 8;

    logic [NUM_RQ-1:0][ADDR_W-1:0] rq_addr;
    logic [NUM_RQ-1:0]             rq_wr_req;
    logic [NUM_RQ-1:0]             rq_rd_req;
    logic [NUM_RQ-1:0][DATA_W-1:0] rq_wdata;
    logic [NUM_RQ-1:0][BE_W-1:0]   rq_wr_byte_en;
    logic [NUM_RQ-1:0]             rq_gnt;
    logic [NUM_RQ-1:0][DATA_W-1:0] rq_rdata;
    logic [NUM_RQ-1:0]             rq_rd_rdy;

    logic [ADDR_W-1:0]             mem_addr;
    logic [DATA_W-1:0]             mem_wdata;
    logic [BE_W-1:0]               mem_wr_byte_en;
    logic                          mem_wr_req;
    logic                          mem_rd_req;
    logic [DATA_W-1:0]             mem_rdata;
    logic                          mem_busy;
    logic                          mem_rd_rdy;

    // Arbiter view
    modport slave (
        input  rq_addr, rq_wr_req, rq_rd_req, rq_wdata, rq_wr_byte_en,
        input  mem_rdata, mem_busy, mem_rd_rdy,
        output rq_gnt, rq_rdata, rq_rd_rdy,
        output mem_addr, mem_wdata, mem_wr_byte_en, mem_wr_req, mem_rd_req
    );

    // Environment view: requesters plus memory controller
    modport master (
        output rq_addr, rq_wr_req, rq_rd_req, rq_wdata, rq_wr_byte_en,
        output mem_rdata, mem_busy, mem_rd_rdy,
        input  rq_gnt, rq_rdata, rq_rd_rdy,
        input  mem_addr, mem_wdata, mem_wr_byte_en, mem_wr_req, mem_rd_req
    );

endinterface

// File: rtl/mem_arb_sel.sv
// rtl/mem_arb_sel.sv - combinational winner select: pointer requester first, else the other one
module mem_arb_sel
    import mem_arb_pkg::*;
(
    input  logic [NUM_RQ-1:0] req_i,
    input  logic              ptr_i,
    output logic              win_idx_o,
    output logic              win_vld_o
);

    always_comb begin
        win_vld_o = |req_i;
        win_idx_o = ptr_i;
        if (!req_i[ptr_i]) begin
            win_idx_o = ~ptr_i;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-requester memory command arbiter with registered command outputs
// Define MEM_ARB_RR_EN for round-robin arbitration; otherwise requester 0 has fixed priority.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic      clk,
    input  logic      reset,
    mem_arb_if.slave  bus_if
);

    localparam int BE_W = DATA_W / 8;

    state_t                        state_q, state_d;
    cmd_t                          cmd_q, cmd_d;
    logic                          owner_q, owner_d;
    logic                          first_q, first_d;
    logic [ADDR_W-1:0]             mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]             mem_wdata_q, mem_wdata_d;
    logic [BE_W-1:0]               mem_be_q, mem_be_d;
    logic                          mem_wr_req_q, mem_wr_req_d;
    logic                          mem_rd_req_q, mem_rd_req_d;
    logic [NUM_RQ-1:0]             gnt_q, gnt_d;
    logic [NUM_RQ-1:0]             rd_rdy_q, rd_rdy_d;
    logic [NUM_RQ-1:0][DATA_W-1:0] rdata_q, rdata_d;

    logic [NUM_RQ-1:0]             req_any;
    logic                          ptr;
    logic                          win_idx;
    logic                          win_vld;

    assign req_any = bus_if.rq_wr_req | bus_if.rq_rd_req;

`ifdef MEM_ARB_RR_EN
    logic ptr_q, ptr_d;

    assign ptr = ptr_q;

    // Hand priority to the requester that just lost once a grant goes out
    always_comb begin
        ptr_d = ptr_q;
        if (state_q == ISSUE) begin
            ptr_d = ~owner_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    assign ptr = 1'b0;
`endif

    mem_arb_sel u_sel (
        .req_i     (req_any),
        .ptr_i     (ptr),
        .win_idx_o (win_idx),
        .win_vld_o (win_vld)
    );

    always_comb begin
        state_d      = state_q;
        cmd_d        = cmd_q;
        owner_d      = owner_q;
        first_d      = first_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_be_d     = mem_be_q;
        mem_wr_req_d = 1'b0;
        mem_rd_req_d = 1'b0;
        gnt_d        = '0;
        rd_rdy_d     = '0;
        rdata_d      = rdata_q;

        case (state_q)
            IDLE: begin
                if (!bus_if.mem_busy && win_vld) begin
                    owner_d     = win_idx;
                    // A simultaneous write and read is served write first
                    cmd_d       = bus_if.rq_wr_req[win_idx] ? CMD_WR : CMD_RD;
                    mem_addr_d  = bus_if.rq_addr[win_idx];
                    mem_wdata_d = bus_if.rq_wdata[win_idx];
                    mem_be_d    = bus_if.rq_wr_byte_en[win_idx];
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                gnt_d[owner_q] = 1'b1;
                if (cmd_q == CMD_WR) begin
                    mem_wr_req_d = 1'b1;
                end else begin
                    mem_rd_req_d = 1'b1;
                end
                first_d = 1'b1;
                state_d = WAIT;
            end
            WAIT: begin
                // The controller cannot have raised busy yet in the cycle the command pulse is out
                first_d = 1'b0;
                if (!first_q) begin
                    if (cmd_q == CMD_WR) begin
                        if (!bus_if.mem_busy) begin
                            state_d = IDLE;
                        end
                    end else if (bus_if.mem_rd_rdy) begin
                        rdata_d[owner_q] = bus_if.mem_rdata;
                        state_d          = RDRET;
                    end
                end
            end
            RDRET: begin
                rd_rdy_d[owner_q] = 1'b1;
                state_d           = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            cmd_q        <= CMD_WR;
            owner_q      <= 1'b0;
            first_q      <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_be_q     <= '0;
            mem_wr_req_q <= 1'b0;
            mem_rd_req_q <= 1'b0;
            gnt_q        <= '0;
            rd_rdy_q     <= '0;
            rdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            cmd_q        <= cmd_d;
            owner_q      <= owner_d;
            first_q      <= first_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_be_q     <= mem_be_d;
            mem_wr_req_q <= mem_wr_req_d;
            mem_rd_req_q <= mem_rd_req_d;
            gnt_q        <= gnt_d;
            rd_rdy_q     <= rd_rdy_d;
            rdata_q      <= rdata_d;
        end
    end

    assign bus_if.rq_gnt         = gnt_q;
    assign bus_if.rq_rd_rdy      = rd_rdy_q;
    assign bus_if.rq_rdata       = rdata_q;
    assign bus_if.mem_addr       = mem_addr_q;
    assign bus_if.mem_wdata      = mem_wdata_q;
    assign bus_if.mem_wr_byte_en = mem_be_q;
    assign bus_if.mem_wr_req     = mem_wr_req_q;
    assign bus_if.mem_rd_req     = mem_rd_req_q;

endmodule
